// File: rtl/byte_serial_add_seq.sv
`default_nettype none
// ============================================================================
// byte_serial_add_seq: wide adder built from one shared 8-bit ripple adder,
// one byte slice per clock, LSB first.                            Rev 1.0
// ============================================================================

module eightbit (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_s,
  output logic       o_c
);
  logic [8:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < 8; g++) begin : g_bit
    assign o_s[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_c = w_c[8];
endmodule

module byte_serial_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [8*NBYTES-1:0] i_a,
  input  logic [8*NBYTES-1:0] i_b,
  input  logic                i_cin,
  output logic                o_ready,
  output logic                o_busy,
  output logic                o_done,
  output logic [8*NBYTES-1:0] o_sum,
  output logic                o_cout
);
  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic [W-1:0]    r_opa;
  logic [W-1:0]    r_opb;
  logic [W-1:0]    r_work;
  logic [W-1:0]    r_sum;
  logic            r_cout;

  logic [7:0]      w_add_a;
  logic [7:0]      w_add_b;
  logic            w_add_cin;
  logic [7:0]      w_add_s;
  logic            w_add_c;
  logic [W-1:0]    w_work_next;
  logic            w_accept;
  logic            w_last;

  assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_idx == C_LAST_IDX);

  // The adder sees zeros whenever no slice is in flight.
  always_comb begin
    w_add_a   = 8'd0;
    w_add_b   = 8'd0;
    w_add_cin = 1'b0;
    if (r_state == S_RUN) begin
      w_add_a   = r_opa[8*r_idx +: 8];
      w_add_b   = r_opb[8*r_idx +: 8];
      w_add_cin = r_carry;
    end
  end

  eightbit u_adder (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_cin (w_add_cin),
    .o_s   (w_add_s),
    .o_c   (w_add_c)
  );

  always_comb begin
    w_work_next               = r_work;
    w_work_next[8*r_idx +: 8] = w_add_s;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last)   w_next = S_DONE;
      S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_work  <= w_work_next;
      r_carry <= w_add_c;
      if (w_last) begin
        r_sum  <= w_work_next;
        r_cout <= w_add_c;
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end else if (w_accept) begin
      r_opa   <= i_a;
      r_opb   <= i_b;
      r_carry <= i_cin;
      r_idx   <= '0;
      r_work  <= '0;
    end
  end

  assign o_ready = (r_state == S_IDLE) || (r_state == S_DONE);
  assign o_busy  = (r_state == S_RUN);
  assign o_done  = (r_state == S_DONE);
  assign o_sum   = r_sum;
  assign o_cout  = r_cout;
endmodule
`default_nettype wire

// File: tb/tb_byte_serial_add_seq.sv
`default_nettype none
// ============================================================================
// tb_byte_serial_add_seq: directed and random checks of the byte-serial adder
// at NBYTES = 1, 2 and 4 against a plain-arithmetic model.         Rev 1.0
// ============================================================================

module tb_byte_serial_add_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        tb_start;
  logic [31:0] tb_a;
  logic [31:0] tb_b;
  logic        tb_cin;
  int          sel;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;

  logic [31:0] prev_sum [3];
  logic        prev_cout[3];

  always #5 clk = ~clk;

  logic       r1, b1, d1, c1;
  logic [7:0] s1;
  logic       r2, b2, d2, c2;
  logic [15:0] s2;
  logic       r4, b4, d4, c4;
  logic [31:0] s4;

  byte_serial_add_seq #(.NBYTES(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(tb_start && (sel == 0)),
    .i_a(tb_a[7:0]), .i_b(tb_b[7:0]), .i_cin(tb_cin),
    .o_ready(r1), .o_busy(b1), .o_done(d1), .o_sum(s1), .o_cout(c1)
  );

  byte_serial_add_seq #(.NBYTES(2)) u_dut2 (
    .clk(clk), .rst(rst), .i_start(tb_start && (sel == 1)),
    .i_a(tb_a[15:0]), .i_b(tb_b[15:0]), .i_cin(tb_cin),
    .o_ready(r2), .o_busy(b2), .o_done(d2), .o_sum(s2), .o_cout(c2)
  );

  byte_serial_add_seq #(.NBYTES(4)) u_dut4 (
    .clk(clk), .rst(rst), .i_start(tb_start && (sel == 2)),
    .i_a(tb_a), .i_b(tb_b), .i_cin(tb_cin),
    .o_ready(r4), .o_busy(b4), .o_done(d4), .o_sum(s4), .o_cout(c4)
  );

  logic        m_ready, m_busy, m_done, m_cout;
  logic [31:0] m_sum;

  always_comb begin
    m_ready = r4; m_busy = b4; m_done = d4; m_cout = c4; m_sum = s4;
    case (sel)
      0: begin m_ready = r1; m_busy = b1; m_done = d1; m_cout = c1; m_sum = {24'd0, s1}; end
      1: begin m_ready = r2; m_busy = b2; m_done = d2; m_cout = c2; m_sum = {16'd0, s2}; end
      default: ;
    endcase
  end

  always @(negedge clk) done_cnt <= done_cnt + int'(d1) + int'(d2) + int'(d4);

  function automatic int nb(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 2 : 4);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  // One operation on the selected DUT; returns at the negedge inside the DONE cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input bit intrude);
    logic [63:0] mask, full, exp_sum, exp_cout;
    int          w, lat, bcnt;
    w        = 8 * nb(sel);
    mask     = (64'd1 << w) - 64'd1;
    full     = ({32'd0, a} & mask) + ({32'd0, b} & mask) + {63'd0, cin};
    exp_sum  = full & mask;
    exp_cout = (full >> w) & 64'd1;
    chk("ready_before_start", m_ready, 1);
    tb_a = a; tb_b = b; tb_cin = cin; tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    acc_cnt++;
    lat  = 0;
    bcnt = 0;
    while (!m_done && lat < 40) begin
      if (m_busy) bcnt++;
      chk("sum_hold_during_run", {m_cout, m_sum}, {prev_cout[sel], prev_sum[sel]});
      if (intrude && lat == 1) begin
        tb_start = 1'b1; tb_a = ~a; tb_b = 32'h5a5a_5a5a; tb_cin = 1'b1;
      end else if (intrude && lat == 2) begin
        tb_start = 1'b0;
      end else if (lat == 0) begin
        tb_a = $urandom; tb_b = $urandom; tb_cin = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    tb_start = 1'b0;
    chk("done_latency", lat, nb(sel));
    chk("busy_cycles", bcnt, nb(sel));
    chk("sum", m_sum, exp_sum);
    chk("cout", m_cout, exp_cout);
    chk("done_ready_busy", {m_ready, m_busy}, 2'b10);
    prev_sum[sel]  = exp_sum[31:0];
    prev_cout[sel] = exp_cout[0];
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      prev_sum[i]  = '0;
      prev_cout[i] = 1'b0;
    end
  endtask

  initial begin
    int d0;
    logic [31:0] ra, rb;
    rst = 1'b1; tb_start = 1'b0; tb_a = '0; tb_b = '0; tb_cin = 1'b0; sel = 0;
    clear_model();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("reset_sum", m_sum, 0);
      chk("reset_flags_rdy_bsy_dn_co", {m_ready, m_busy, m_done, m_cout}, 4'b1000);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single-byte case with overflow into cout.
    sel = 0; #1;
    run_op(32'd236, 32'd34, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Carry ripple across three slices.
    sel = 2; #1;
    run_op(32'h00FF_FFFF, 32'd1, 1'b0, 1'b0);
    @(negedge clk);

    // Full wrap to zero; result must hold while idle.
    run_op(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("idle_hold_sum", m_sum, 0);
    chk("idle_hold_cout", m_cout, 1);
    chk("idle_ready_busy_done", {m_ready, m_busy, m_done}, 3'b100);

    // Start while busy is ignored; start during DONE is accepted back-to-back.
    run_op(32'd99, 32'd67, 1'b0, 1'b1);
    run_op(32'd236, 32'd34, 1'b0, 1'b0);
    @(negedge clk);

    // Asynchronous reset mid-operation abandons the operation.
    tb_a = 32'h1234_5678; tb_b = 32'h1111_1111; tb_cin = 1'b0; tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sum", m_sum, 0);
    chk("async_rst_flags", {m_ready, m_busy, m_done, m_cout}, 4'b1000);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (8) @(negedge clk);
    chk("no_done_after_rst", done_cnt, d0);
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    @(negedge clk);

    // Random operands with mixed back-to-back and idle gaps.
    for (int s = 1; s < 3; s++) begin
      sel = s; #1;
      for (int i = 0; i < 500; i++) begin
        ra = $urandom; rb = $urandom;
        if (i % 10 == 0) ra = 32'hFFFF_FFFF;
        run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
        if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      repeat (2) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("done_count_vs_accepted", done_cnt, acc_cnt);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
